// File: rtl/song_player.sv
// song_player: walks the song ROM, holds each note for NOTE_CYCLES then GAP_CYCLES of silence, and toggles speaker every note_q clocks (define SONG_LOOP_EN to repeat the song until stop)
module song_player #(
  parameter int NOTE_CYCLES = 25000000,
  parameter int GAP_CYCLES = 2500000,
  parameter int SONG_LEN = 26,
  parameter int NOTE_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic stop,
  output logic [4:0] rom_addr,
  input  logic [NOTE_W-1:0] rom_note,
  output logic speaker,
  output logic busy,
  output logic done
);
  localparam int MX = NOTE_CYCLES > GAP_CYCLES ? NOTE_CYCLES : GAP_CYCLES;
  localparam int DW = MX > 1 ? $clog2(MX) : 1;
  localparam logic [DW-1:0] NOTE_LAST = DW'(NOTE_CYCLES - 1);
  localparam logic [DW-1:0] GAP_LAST = DW'(GAP_CYCLES - 1);
  localparam logic [4:0] ADDR_LAST = 5'(SONG_LEN - 1);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP, DONE} state_t;
  state_t state;
  logic [DW-1:0] dur_cnt;
  logic [NOTE_W-1:0] tone_cnt, note_q;
  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (!rst_n) begin
      state <= IDLE;
      rom_addr <= '0;
      speaker <= 1'b0;
      busy <= 1'b0;
      dur_cnt <= '0;
      tone_cnt <= '0;
      note_q <= '0;
    end else if (stop && state != IDLE) begin
      state <= IDLE;
      rom_addr <= '0;
      speaker <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start && !stop) begin
          state <= FETCH;
          rom_addr <= '0;
          busy <= 1'b1;
        end
        FETCH: state <= LOAD;
        LOAD: begin
          note_q <= rom_note;
          dur_cnt <= '0;
          tone_cnt <= '0;
          state <= PLAY;
        end
        PLAY: begin
          dur_cnt <= dur_cnt + DW'(1);
          if (note_q == '0) speaker <= 1'b0;
          else if (tone_cnt == note_q - NOTE_W'(1)) begin
            speaker <= ~speaker;
            tone_cnt <= '0;
          end else tone_cnt <= tone_cnt + NOTE_W'(1);
          if (dur_cnt == NOTE_LAST) begin
            state <= GAP;
            dur_cnt <= '0;
            speaker <= 1'b0;
          end
        end
        GAP: begin
          dur_cnt <= dur_cnt + DW'(1);
          speaker <= 1'b0;
          if (dur_cnt == GAP_LAST) begin
            dur_cnt <= '0;
            if (rom_addr == ADDR_LAST) begin
`ifdef SONG_LOOP_EN
              rom_addr <= '0;
              state <= FETCH;
`else
              state <= DONE;
              done <= 1'b1;
`endif
            end else begin
              rom_addr <= rom_addr + 5'd1;
              state <= FETCH;
            end
          end
        end
        DONE: begin
          rom_addr <= '0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_song_player.sv
// tb_song_player: randomized and directed checks of song_player against a per-cycle arithmetic model of the song timeline
module tb_song_player;
  localparam int NC = 20;
  localparam int GC = 4;
  localparam int LEN = 3;
  localparam int P = NC + GC + 2;
  localparam int SONG = LEN * P;
`ifdef SONG_LOOP_EN
  localparam int LOOPS = 3;
`else
  localparam int LOOPS = 1;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic [4:0] rom_addr;
  logic [15:0] rom_note;
  logic speaker, busy, done;
  logic [15:0] rom [32];
  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  song_player #(.NOTE_CYCLES(NC), .GAP_CYCLES(GC), .SONG_LEN(LEN), .NOTE_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .rom_addr(rom_addr),
    .rom_note(rom_note), .speaker(speaker), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) rom_note <= rom[rom_addr];
  always @(posedge clk) if (done === 1'b1) n_done++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] model(input int t);
    int u, k, p, n;
`ifdef SONG_LOOP_EN
    u = t % SONG;
`else
    if (t >= SONG) return (t == SONG) ? {5'(LEN - 1), 3'b011} : 8'h00;
    u = t;
`endif
    k = u / P;
    p = u % P - 2;
    n = int'(rom[k]);
    return {5'(k), (p >= 0 && p < NC && n != 0) ? 1'((p / n) % 2) : 1'b0, 2'b10};
  endfunction
  task automatic chk_idle(input string tag);
    chk({tag, " addr"}, 32'(rom_addr), 32'd0);
    chk({tag, " speaker"}, 32'(speaker), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
  endtask
  task automatic fill(input int mode);
    for (int i = 0; i < 32; i++)
      rom[i] = mode < 0 ? 16'($urandom_range(0, 7)) : 16'(mode);
  endtask
  task automatic run(input string tag, input int poke, input int cut, input bit by_rst);
    int lim;
    int d0;
    logic [7:0] e;
    lim = LOOPS * SONG + 3;
    d0 = n_done;
    start = 1'b1;
    @(posedge clk);
    for (int t = 0; t < lim; t++) begin
      @(negedge clk);
      start = (t == poke);
      if (t == cut) begin
        chk_idle({tag, " cut"});
        stop = 1'b0;
        rst_n = 1'b1;
        break;
      end
      e = model(t);
      chk($sformatf("%s addr t=%0d", tag, t), 32'(rom_addr), 32'(e[7:3]));
      chk($sformatf("%s speaker t=%0d", tag, t), 32'(speaker), 32'(e[2]));
      chk($sformatf("%s busy t=%0d", tag, t), 32'(busy), 32'(e[1]));
      chk($sformatf("%s done t=%0d", tag, t), 32'(done), 32'(e[0]));
      if (t == cut - 1) begin
        if (by_rst) rst_n = 1'b0;
        else stop = 1'b1;
      end
    end
`ifdef SONG_LOOP_EN
    if (cut < 0) begin
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk_idle({tag, " loop stop"});
    end
    chk({tag, " done count"}, 32'(n_done - d0), 32'd0);
`else
    chk({tag, " done count"}, 32'(n_done - d0), cut < 0 ? 32'd1 : 32'd0);
`endif
  endtask
  initial begin
    fill(-1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_idle("reset");
    run("rand song", -1, -1, 1'b0);
    fill(3);
    run("note3", -1, -1, 1'b0);
    fill(0);
    run("rest", -1, -1, 1'b0);
    fill(1);
    rom[1] = 16'd2;
    run("fast toggle", -1, -1, 1'b0);
    fill(-1);
    run("stop note1", -1, P + 10, 1'b0);
    run("replay", -1, -1, 1'b0);
    run("start midsong", 30, -1, 1'b0);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    chk_idle("start+stop");
    repeat (3) @(negedge clk);
    chk_idle("start+stop later");
    fill(-1);
    run("reset midplay", -1, P + 8, 1'b1);
    repeat (2) @(negedge clk);
    chk_idle("after reset");
    run("after reset song", -1, -1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/song_player.md
# song_player

Sequencer for the birthday-song ROM. On `start`, it walks the ROM addresses in order and holds each note for a fixed duration, separated by a short silent gap. From each note's half-period value it generates a square-wave `speaker` output. It sits between the board's start/stop buttons (already debounced) and the speaker pin, and is the only master of the ROM `address` bus.

## Interface
Parameters:
- `NOTE_CYCLES`, 25000000: clocks each note sounds (0.5 s at 50 MHz); must be ≥1.
- `GAP_CYCLES`, 2500000: silent clocks after each note; must be ≥1.
- `SONG_LEN`, 26: number of ROM entries played, addresses 0..SONG_LEN-1; must be 1..32.
- `NOTE_W`, 16: width of the ROM note word (half-period in clocks).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request to begin playback; ignored unless IDLE.
- `stop`  in  1  abort playback; level or pulse.
- `rom_addr`  out  5  drives ROM `address`.
- `rom_note`  in  NOTE_W  ROM `note` output, registered in the ROM, 1-cycle read latency.
- `speaker`  out  1  square-wave tone output.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the last note's gap completes.

## Operation
- States: IDLE, FETCH, LOAD, PLAY, GAP, DONE. All outputs are registered.
- Reset (`rst_n`=0 at an edge): state=IDLE, `rom_addr`=0, `speaker`=0, `busy`=0, `done`=0. All counters and `note_q` are cleared. Reset overrides every other input, including mid-note.
- IDLE: `start`=1 → FETCH with `rom_addr`=0.
- FETCH: 1 cycle. `rom_addr` is stable and the ROM registers the note at the end of this cycle. Next state is LOAD.
- LOAD: 1 cycle. Capture `note_q`←`rom_note` and clear `dur_cnt` and `tone_cnt`. Next state is PLAY.
- PLAY: lasts exactly NOTE_CYCLES cycles.
  - `dur_cnt` increments each cycle. At NOTE_CYCLES-1, go to GAP.
  - Tone generation: if `note_q`≠0, `tone_cnt` counts 0..`note_q`-1. At `note_q`-1, `speaker` toggles and `tone_cnt` wraps to 0. The half-period is therefore `note_q` clocks.
  - If `note_q`=0, this is a rest: `speaker` is held 0.
- GAP: lasts exactly GAP_CYCLES cycles, with `speaker` forced 0 on entry.
  - On exit, if `rom_addr`=SONG_LEN-1, go to DONE.
  - Otherwise `rom_addr`←`rom_addr`+1 and go to FETCH.
- DONE: 1 cycle with `done`=1. `rom_addr`←0, then go to IDLE.
- `stop`=1 in any non-IDLE state: next state is IDLE with `rom_addr`=0 and `speaker`=0. `done` is not asserted.
- `start` and `stop` both high in IDLE: `stop` wins, and the block stays IDLE.
- `start` while busy: no effect. Playback is not restarted.
- `dur_cnt` width is clog2(max(NOTE_CYCLES,GAP_CYCLES)). It is shared by PLAY and GAP and cleared on each state entry.
- `tone_cnt` is NOTE_W bits wide. The compare uses `note_q`-1 computed at NOTE_W width; the `note_q`=0 case is guarded separately.

## Timing
- `start` sampled at edge 0: `busy`=1 and FETCH from edge 0.
  - LOAD from edge 1.
  - PLAY from edge 2.
  - First `speaker` toggle at edge 2+`note_q`.
- Per-note period: 2 + NOTE_CYCLES + GAP_CYCLES clocks.
- Whole song: SONG_LEN×(2+NOTE_CYCLES+GAP_CYCLES) clocks from `start`, then 1 DONE cycle. `busy` falls on the edge after `done`.
- Stop latency is 1 clock, from any state.
- `speaker` phase restarts at 0 at every note, because the counters are cleared in LOAD.

## Configuration
- `SONG_LOOP_EN` defined: on GAP exit at the last address, `rom_addr`←0 and the block goes to FETCH. The song repeats until `stop` or reset, and `done` never pulses.
- `SONG_LOOP_EN` undefined: the block plays once, pulses `done`, and returns to IDLE, as described above.

## Test plan
Bench parameters: NOTE_CYCLES=20, GAP_CYCLES=4, SONG_LEN=3, driving the real ROM model.
- Reset then `start` pulse:
  - `rom_addr` sequence is 0,1,2.
  - `done` pulses once, 78 clocks after `start`.
  - `busy` is high for 79 clocks.
  - `rom_addr` is 0 at the end.
- ROM stub returning `note`=3: during PLAY, `speaker` toggles every 3 clocks, with the first toggle 5 clocks after `start`.
  - `speaker`=0 throughout the gap.
- ROM stub returning `note`=0: `speaker` stays 0 for the entire song, and timing is unchanged.
- `stop` asserted 10 clocks into note 1: on the next clock the state is IDLE, `speaker`=0, `rom_addr`=0, `busy`=0, and there is no `done`.
  - A second `start` replays from address 0.
- `start` pulsed again mid-song, and `start`+`stop` together in IDLE: no restart and no address change; the block remains IDLE.
- `rst_n`=0 for 1 clock mid-PLAY: all outputs are at reset values on the next clock.
  - With `SONG_LOOP_EN` defined: after address 2, address 0 is refetched, and `done` is never seen across 3 loops.
